// File: rtl/bram_arbiter_if.sv
// Bus bundle for bram_arbiter: Wishbone slave side, user req/ack side, BRAM port.
// The slave modport is the arbiter's view; master is the view of whatever
// drives the requests and models the BRAM.
interface bram_arbiter_if;
  // Wishbone (Caravel) side, port A
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  // User req/ack side, port B
  logic        b_req;
  logic [3:0]  b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;

  // Single BRAM port
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_di;
  logic [31:0] bram_do;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata,
    output bram_en, bram_we, bram_addr, bram_di,
    input  bram_do
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  bram_en, bram_we, bram_addr, bram_di,
    output bram_do
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin sharing of one single-port BRAM between a Wishbone slave (A) and a req/ack master (B).
// Latency: owner's ack 3+DELAYS cycles after the IDLE grant cycle; one access per 4+DELAYS cycles.
// Backpressure: losing requester simply waits (A: ack withheld, B: b_ack withheld); nothing is dropped.
module bram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFC0_0000,
  parameter int unsigned DELAYS    = 10
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  bram_arbiter_if.slave bus
);

  // Owner / last-grant encoding
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Terminal count of the wait counter; unused when DELAYS is 0
  localparam logic [7:0] CNT_LAST = (DELAYS == 0) ? 8'd0 : 8'(DELAYS - 1);
  localparam logic       HAS_WAIT = (DELAYS != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_LATCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q;
  logic        last_grant_q;
  logic [3:0]  we_q;
  logic [31:0] addr_q;
  logic [31:0] di_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt_q;

  logic        req_a;
  logic        req_b;
  logic        grant;
  logic        grant_b;
  logic        resp_a;
  logic        resp_b;
  logic [31:0] a_word_addr;

  // Port A only requests when the address decodes into our window
  assign req_a       = bus.wbs_cyc_i & bus.wbs_stb_i &
                       ((bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign req_b       = bus.b_req;
  assign a_word_addr = (bus.wbs_adr_i - BASE_ADDR) >> 2;

  // Next-state and grant decision; grant only happens in IDLE
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          grant   = 1'b1;
          // On a tie, the port that did not win last time goes now
          grant_b = req_b && (!req_a || (last_grant_q == OWN_A));
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_LATCH;
      S_LATCH:  state_d = HAS_WAIT ? S_WAIT : S_RESP;
      S_WAIT:   state_d = (cnt_q == CNT_LAST) ? S_RESP : S_WAIT;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any partially sequenced access
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request so the requester may change its inputs afterwards
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      owner_q      <= OWN_A;
      last_grant_q <= OWN_B;
      we_q         <= 4'h0;
      addr_q       <= 32'h0;
      di_q         <= 32'h0;
    end else if (grant) begin
      owner_q      <= grant_b;
      last_grant_q <= grant_b;
      if (grant_b) begin
        we_q   <= bus.b_we;
        addr_q <= bus.b_addr;
        di_q   <= bus.b_wdata;
      end else begin
        we_q   <= bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
        addr_q <= a_word_addr;
        di_q   <= bus.wbs_dat_i;
      end
    end
  end

  // Read data is taken the cycle after ACCESS; wait counter restarts from zero each access
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rdata_q <= 32'h0;
      cnt_q   <= 8'h0;
    end else begin
      if (state_q == S_LATCH) begin
        rdata_q <= bus.bram_do;
        cnt_q   <= 8'h0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + 8'h1;
      end
    end
  end

  // BRAM strobes only in ACCESS; address/data stay parked on the last latched values
  assign bus.bram_en   = (state_q == S_ACCESS) && !wb_rst_i;
  assign bus.bram_we   = bus.bram_en ? we_q : 4'h0;
  assign bus.bram_addr = addr_q;
  assign bus.bram_di   = di_q;

  // Completion; a Wishbone master that has dropped cyc gets no ack
  assign resp_a        = (state_q == S_RESP) && (owner_q == OWN_A) && !wb_rst_i;
  assign resp_b        = (state_q == S_RESP) && (owner_q == OWN_B) && !wb_rst_i;
  assign bus.wbs_ack_o = resp_a && bus.wbs_cyc_i;
  assign bus.wbs_dat_o = bus.wbs_ack_o ? rdata_q : 32'h0;
  assign bus.b_ack     = resp_b;
  assign bus.b_rdata   = resp_b ? rdata_q : 32'h0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: one instance with DELAYS=10, one with DELAYS=0,
// each attached to a behavioural single-port BRAM (registered read, Do=0 when EN=0).
module tb_bram_arbiter;

  localparam logic [31:0] BASE = 32'h3800_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_arbiter_if bus1();
  bram_arbiter_if bus0();

  bram_arbiter #(.BASE_ADDR(BASE), .ADDR_MASK(32'hFFC0_0000), .DELAYS(10)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus1)
  );
  bram_arbiter #(.BASE_ADDR(BASE), .ADDR_MASK(32'hFFC0_0000), .DELAYS(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus0)
  );

  // BRAM models (read-first on writes)
  logic [31:0] mem1 [0:255];
  logic [31:0] mem0 [0:255];

  always @(posedge clk) begin
    if (bus1.bram_en) begin
      bus1.bram_do <= mem1[bus1.bram_addr[7:0]];
      for (int i = 0; i < 4; i++)
        if (bus1.bram_we[i]) mem1[bus1.bram_addr[7:0]][8*i +: 8] <= bus1.bram_di[8*i +: 8];
    end else begin
      bus1.bram_do <= 32'h0;
    end
  end

  always @(posedge clk) begin
    if (bus0.bram_en) begin
      bus0.bram_do <= mem0[bus0.bram_addr[7:0]];
      for (int j = 0; j < 4; j++)
        if (bus0.bram_we[j]) mem0[bus0.bram_addr[7:0]][8*j +: 8] <= bus0.bram_di[8*j +: 8];
    end else begin
      bus0.bram_do <= 32'h0;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  // Results of the last transfer task
  int          ack_cyc;
  logic [31:0] ack_dat;
  int          en_cyc;
  logic [3:0]  en_we;
  logic [31:0] en_addr;
  logic [31:0] en_di;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer on the DELAYS=10 instance; cycle 0 is the grant cycle
  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat);
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 1'b1; bus1.wbs_stb_i = 1'b1; bus1.wbs_we_i = we;
    bus1.wbs_sel_i = sel;  bus1.wbs_adr_i = adr;  bus1.wbs_dat_i = dat;
    ack_cyc = -1; en_cyc = -1; ack_dat = 32'h0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus1.bram_en && en_cyc < 0) begin
        en_cyc = c; en_we = bus1.bram_we; en_addr = bus1.bram_addr; en_di = bus1.bram_di;
      end
      if (bus1.wbs_ack_o) begin
        ack_cyc = c; ack_dat = bus1.wbs_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 1'b0; bus1.wbs_stb_i = 1'b0; bus1.wbs_we_i = 1'b0;
  endtask

  // One port-B transfer on the DELAYS=0 instance
  task automatic b_xfer0(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    bus0.b_req = 1'b1; bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wdata;
    ack_cyc = -1; en_cyc = -1; ack_dat = 32'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus0.bram_en && en_cyc < 0) begin
        en_cyc = c; en_we = bus0.bram_we; en_addr = bus0.bram_addr; en_di = bus0.bram_di;
      end
      if (bus0.b_ack) begin
        ack_cyc = c; ack_dat = bus0.b_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    bus0.b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ord [4];
    int          ocyc [4];
    int          n;
    int          en_cnt;
    int          ack_cnt;

    bus1.wbs_cyc_i = 0; bus1.wbs_stb_i = 0; bus1.wbs_we_i = 0; bus1.wbs_sel_i = 0;
    bus1.wbs_adr_i = 0; bus1.wbs_dat_i = 0; bus1.b_req = 0; bus1.b_we = 0;
    bus1.b_addr = 0; bus1.b_wdata = 0;
    bus0.wbs_cyc_i = 0; bus0.wbs_stb_i = 0; bus0.wbs_we_i = 0; bus0.wbs_sel_i = 0;
    bus0.wbs_adr_i = 0; bus0.wbs_dat_i = 0; bus0.b_req = 0; bus0.b_we = 0;
    bus0.b_addr = 0; bus0.b_wdata = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_wbs_ack", 32'(bus1.wbs_ack_o), 32'h0);
    chk("rst_wbs_dat", bus1.wbs_dat_o, 32'h0);
    chk("rst_b_ack", 32'(bus1.b_ack), 32'h0);
    chk("rst_b_rdata", bus1.b_rdata, 32'h0);
    chk("rst_bram_en", 32'(bus1.bram_en), 32'h0);
    chk("rst_bram_we", 32'(bus1.bram_we), 32'h0);
    chk("rst_bram_addr", bus1.bram_addr, 32'h0);
    chk("rst_bram_di", bus1.bram_di, 32'h0);

    // T3: simultaneous A and B writes held high -> A,B,A,B every 14 cycles
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 1; bus1.wbs_stb_i = 1; bus1.wbs_we_i = 1; bus1.wbs_sel_i = 4'hF;
    bus1.wbs_adr_i = BASE + 32'h14; bus1.wbs_dat_i = 32'h0A0A_0A0A;
    bus1.b_req = 1; bus1.b_we = 4'hF; bus1.b_addr = 32'd6; bus1.b_wdata = 32'h0B0B_0B0B;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      if (bus1.wbs_ack_o) begin ord[n] = 0; ocyc[n] = c; n++; end
      else if (bus1.b_ack) begin ord[n] = 1; ocyc[n] = c; n++; end
    end
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 0; bus1.wbs_stb_i = 0; bus1.wbs_we_i = 0; bus1.b_req = 0;
    chk("t3_count", 32'(n), 32'd4);
    chk("t3_grant0", 32'(ord[0]), 32'd0);
    chk("t3_grant1", 32'(ord[1]), 32'd1);
    chk("t3_grant2", 32'(ord[2]), 32'd0);
    chk("t3_grant3", 32'(ord[3]), 32'd1);
    chk("t3_cyc0", 32'(ocyc[0]), 32'd13);
    chk("t3_cyc1", 32'(ocyc[1]), 32'd27);
    chk("t3_mem_a", mem1[5], 32'h0A0A_0A0A);
    chk("t3_mem_b", mem1[6], 32'h0B0B_0B0B);

    // T1: full write then read-back
    wb_xfer(1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF);
    chk("t1_en_cyc", 32'(en_cyc), 32'd1);
    chk("t1_en_we", 32'(en_we), 32'hF);
    chk("t1_en_addr", en_addr, 32'd4);
    chk("t1_en_di", en_di, 32'hDEAD_BEEF);
    chk("t1_ack_cyc", 32'(ack_cyc), 32'd13);
    wb_xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    chk("t1_rd_we", 32'(en_we), 32'h0);
    chk("t1_rd_ack_cyc", 32'(ack_cyc), 32'd13);
    chk("t1_rd_dat", ack_dat, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_dat_after", bus1.wbs_dat_o, 32'h0);

    // T2: single byte lane write
    wb_xfer(1'b1, 4'b0100, BASE + 32'h10, 32'h00AA_0000);
    chk("t2_en_we", 32'(en_we), 32'h4);
    wb_xfer(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    chk("t2_rd_dat", ack_dat, 32'hDEAA_BEEF);

    // T4: DELAYS=0 instance, B write then B read of word 7
    b_xfer0(4'hF, 32'd7, 32'h1234_5678);
    chk("t4_wr_ack_cyc", 32'(ack_cyc), 32'd3);
    b_xfer0(4'h0, 32'd7, 32'h0);
    chk("t4_en_cyc", 32'(en_cyc), 32'd1);
    chk("t4_en_addr", en_addr, 32'd7);
    chk("t4_ack_cyc", 32'(ack_cyc), 32'd3);
    chk("t4_rdata", ack_dat, 32'h1234_5678);
    @(negedge clk);
    chk("t4_rdata_after", bus0.b_rdata, 32'h0);
    chk("t4_ack_after", 32'(bus0.b_ack), 32'h0);

    // T5: reset during WAIT with the request held; it is then served afresh
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 1; bus1.wbs_stb_i = 1; bus1.wbs_we_i = 0; bus1.wbs_sel_i = 4'hF;
    bus1.wbs_adr_i = BASE + 32'h10;
    ack_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus1.wbs_ack_o) ack_cnt++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (bus1.wbs_ack_o) ack_cnt++;
    chk("t5_en_in_rst", 32'(bus1.bram_en), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ack_cyc = -1; en_cyc = -1; ack_dat = 32'h0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus1.bram_en && en_cyc < 0) en_cyc = c;
      if (bus1.wbs_ack_o) begin ack_cyc = c; ack_dat = bus1.wbs_dat_o; break; end
    end
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 0; bus1.wbs_stb_i = 0;
    chk("t5_no_ack_before_rst", 32'(ack_cnt), 32'd0);
    chk("t5_en_cyc", 32'(en_cyc), 32'd1);
    chk("t5_ack_cyc", 32'(ack_cyc), 32'd13);
    chk("t5_dat", ack_dat, 32'hDEAA_BEEF);

    // T6: address outside the window is ignored
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 1; bus1.wbs_stb_i = 1; bus1.wbs_we_i = 1; bus1.wbs_sel_i = 4'hF;
    bus1.wbs_adr_i = 32'h3000_0000; bus1.wbs_dat_i = 32'h5555_5555;
    en_cnt = 0; ack_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus1.bram_en) en_cnt++;
      if (bus1.wbs_ack_o) ack_cnt++;
    end
    @(posedge clk); #1;
    bus1.wbs_cyc_i = 0; bus1.wbs_stb_i = 0; bus1.wbs_we_i = 0;
    chk("t6_en_count", 32'(en_cnt), 32'd0);
    chk("t6_ack_count", 32'(ack_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
